stress_signature_misr: RTL and testbench

//  Downstream consumer of the pseudorandom flip-flop stress generator.
//  - Compacts {dummy, dummy_address, dummy_data} every cycle into a 32-bit MISR signature.
//  - Counts bit toggles per fixed window and offers the result on a valid/ready port.
//  - Flags a stuck generator, so bench and silicon can prove the flops are really switching.

---
 rtl/stress_test_pkg.sv | 26 ++
 rtl/signature_misr.sv | 29 ++
 rtl/stress_signature_misr.sv | 146 ++++++++++++++
 tb/tb_stress_signature_misr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stress_test_pkg.sv
// Shared types and helpers for the stress-generator signature checker.
// Keeps the input width, MISR defaults and the held result layout in one place.
package stress_test_pkg;

   localparam int IN_W = 33;
   localparam int RESULT_TOGGLE_W = 32;
   localparam logic [31:0] DEFAULT_MISR_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEFAULT_MISR_SEED = 32'hFFFFFFFF;

   // Toggle field is sized for the widest supported accumulator; the top truncates.
   typedef struct packed {
      logic [31:0]                signature;
      logic [RESULT_TOGGLE_W-1:0] toggles;
      logic                       overrun;
   } stress_result_t;

   function automatic logic [5:0] popcount33(input logic [IN_W-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < IN_W; i++) begin
         c = c + {5'b0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/signature_misr.sv
// 32-bit multiple-input signature register with seed reload.
// sig_next_o exposes the post-step value so a window result can be captured on the reload edge.
module signature_misr #(
   parameter logic [31:0] POLY = 32'h04C11DB7,
   parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step_i,
   input  logic        seed_load_i,
   input  logic [31:0] fold_i,
   output logic [31:0] sig_o,
   output logic [31:0] sig_next_o
);

   logic [31:0] sig_q;

   assign sig_next_o = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold_i;
   assign sig_o      = sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= SEED;
      end else if (step_i) begin
         sig_q <= seed_load_i ? SEED : sig_next_o;
      end
   end

endmodule

// File: rtl/stress_signature_misr.sv
// Compacts the stress generator outputs into a per-window MISR signature and toggle count,
// offers each window result on a valid/ready port, and flags a generator that stopped switching.
module stress_signature_misr
   import stress_test_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES = 1024,
   parameter logic [31:0] MISR_POLY     = DEFAULT_MISR_POLY,
   parameter logic [31:0] MISR_SEED     = DEFAULT_MISR_SEED,
   parameter int unsigned STUCK_CYCLES  = 64,
   parameter int unsigned TOGGLE_WIDTH  = 24
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    enable,
   input  logic                    dummy,
   input  logic [15:0]             dummy_address,
   input  logic [15:0]             dummy_data,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [31:0]             result_signature,
   output logic [TOGGLE_WIDTH-1:0] result_toggles,
   output logic                    result_overrun,
   output logic                    stuck
);

   localparam int WCNT_W = $clog2(WINDOW_CYCLES + 1);
   localparam int SCNT_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WINDOW_CYCLES - 1);
   localparam logic [SCNT_W-1:0] STUCK_MAX = SCNT_W'(STUCK_CYCLES);

   logic [IN_W-1:0]         in_q, in_prev_q, in_prev_d;
   logic                    en_q, prev_valid_q, prev_valid_d;
   logic [TOGGLE_WIDTH-1:0] acc_q, acc_d, acc_next;
   logic [TOGGLE_WIDTH:0]   acc_sum;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic [SCNT_W-1:0]       scnt_q, scnt_d;
   logic                    valid_q, valid_d;
   stress_result_t          res_q, res_d, cand;
   logic [5:0]              tog;
   logic [31:0]             fold, misr_sig, misr_next;
   logic                    win_done, xfer;
   logic                    unused_res_bits;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_q <= '0;
         en_q <= 1'b0;
      end else begin
         in_q <= {dummy, dummy_address, dummy_data};
         en_q <= enable;
      end
   end

   assign fold     = in_q[31:0] ^ {31'b0, in_q[IN_W-1]};
   assign win_done = en_q && (wcnt_q == WIN_LAST);
   assign xfer     = valid_q && result_ready;

   signature_misr #(
      .POLY (MISR_POLY),
      .SEED (MISR_SEED)
   ) u_misr (
      .clk         (clk),
      .rst_n       (resetn),
      .step_i      (en_q),
      .seed_load_i (win_done),
      .fold_i      (fold),
      .sig_o       (misr_sig),
      .sig_next_o  (misr_next)
   );

   // First update after reset or a pause has no valid predecessor to compare against.
   assign tog      = prev_valid_q ? popcount33(in_q ^ in_prev_q) : 6'd0;
   assign acc_sum  = {1'b0, acc_q} + (TOGGLE_WIDTH + 1)'(tog);
   assign acc_next = acc_sum[TOGGLE_WIDTH] ? '1 : acc_sum[TOGGLE_WIDTH-1:0];

   always_comb begin
      in_prev_d    = in_prev_q;
      prev_valid_d = 1'b0;
      acc_d        = acc_q;
      wcnt_d       = wcnt_q;
      scnt_d       = scnt_q;
      if (en_q) begin
         in_prev_d    = in_q;
         prev_valid_d = 1'b1;
         if (win_done) begin
            acc_d  = '0;
            wcnt_d = '0;
         end else begin
            acc_d  = acc_next;
            wcnt_d = wcnt_q + 1'b1;
         end
         if (tog != 6'd0) begin
            scnt_d = '0;
         end else if (prev_valid_q && (scnt_q != STUCK_MAX)) begin
            scnt_d = scnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      cand.signature = misr_next;
      cand.toggles   = RESULT_TOGGLE_W'(acc_next);
      cand.overrun   = 1'b0;
      res_d          = res_q;
      valid_d        = valid_q;
      if (win_done && (!valid_q || xfer)) begin
         res_d   = cand;
         valid_d = 1'b1;
      end else if (win_done) begin
         res_d.overrun = 1'b1;
      end else if (xfer) begin
         valid_d       = 1'b0;
         res_d.overrun = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_prev_q    <= '0;
         prev_valid_q <= 1'b0;
         acc_q        <= '0;
         wcnt_q       <= '0;
         scnt_q       <= '0;
         valid_q      <= 1'b0;
         res_q        <= '0;
      end else begin
         in_prev_q    <= in_prev_d;
         prev_valid_q <= prev_valid_d;
         acc_q        <= acc_d;
         wcnt_q       <= wcnt_d;
         scnt_q       <= scnt_d;
         valid_q      <= valid_d;
         res_q        <= res_d;
      end
   end

   // Upper toggle bits and the live MISR value are not part of the output contract.
   assign unused_res_bits  = ^{res_q.toggles, misr_sig};

   assign result_valid     = valid_q;
   assign result_signature = res_q.signature;
   assign result_toggles   = res_q.toggles[TOGGLE_WIDTH-1:0];
   assign result_overrun   = res_q.overrun;
   assign stuck            = (scnt_q == STUCK_MAX);

endmodule

// File: tb/tb_stress_signature_misr.sv
// Scoreboard bench for stress_signature_misr with a 4-update window and 8-update stuck limit.
module tb_stress_signature_misr;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;
   localparam int WIN = 4;

   logic        clk, resetn, enable, dummy, result_ready;
   logic [15:0] dummy_address, dummy_data;
   logic        result_valid, result_overrun, stuck;
   logic [31:0] result_signature;
   logic [23:0] result_toggles;

   stress_signature_misr #(
      .WINDOW_CYCLES (4),
      .STUCK_CYCLES  (8)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .enable           (enable),
      .dummy            (dummy),
      .dummy_address    (dummy_address),
      .dummy_data       (dummy_data),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .result_signature (result_signature),
      .result_toggles   (result_toggles),
      .result_overrun   (result_overrun),
      .stuck            (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sig;
      logic [23:0] tog;
      logic        ovr;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] m_misr;
   int          m_acc, m_cnt;
   logic        m_pv, drop_mode;
   logic [32:0] m_prev;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_misr = SEED;
      m_acc  = 0;
      m_cnt  = 0;
      m_pv   = 1'b0;
      m_prev = '0;
   endtask

   task automatic model_update(input logic d, input logic [15:0] a, input logic [15:0] dat);
      logic [32:0] v;
      int          t;
      exp_t        e;
      v      = {d, a, dat};
      t      = m_pv ? $countones(v ^ m_prev) : 0;
      m_misr = {m_misr[30:0], 1'b0} ^ (m_misr[31] ? POLY : 32'h0) ^ {a, dat} ^ {31'b0, d};
      m_acc  = m_acc + t;
      if (m_acc > 24'hFFFFFF) m_acc = 24'hFFFFFF;
      m_prev = v;
      m_pv   = 1'b1;
      m_cnt++;
      if (m_cnt == WIN) begin
         if (drop_mode && sb.size() > 0) begin
            sb[sb.size()-1].ovr = 1'b1;
         end else begin
            e.sig = m_misr;
            e.tog = 24'(m_acc);
            e.ovr = 1'b0;
            sb.push_back(e);
         end
         m_misr = SEED;
         m_acc  = 0;
         m_cnt  = 0;
      end
   endtask

   // Inputs applied now are captured at the next edge; the model sees them as one update.
   task automatic drv(input logic en, input logic d, input logic [15:0] a,
                      input logic [15:0] dat, input logic rdy);
      enable        = en;
      dummy         = d;
      dummy_address = a;
      dummy_data    = dat;
      result_ready  = rdy;
      if (en) model_update(d, a, dat);
      else    m_pv = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      sb.delete();
      enable = 1'b0;
      result_ready = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic drain();
      repeat (3) drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      chk("sb_empty", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (resetn && result_valid && result_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_signature", 64'(result_signature), 64'(mon_e.sig));
            chk("sb_toggles", 64'(result_toggles), 64'(mon_e.tog));
            chk("sb_overrun", 64'(result_overrun), 64'(mon_e.ovr));
         end
      end
   end

   initial begin
      int seen;
      logic [15:0] alt;
      resetn = 1'b0; enable = 1'b0; dummy = 1'b0;
      dummy_address = '0; dummy_data = '0; result_ready = 1'b0;
      drop_mode = 1'b0;
      model_reset();

      // reset state and idle
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_signature", 64'(result_signature), 64'd0);
      chk("rst_toggles", 64'(result_toggles), 64'd0);
      chk("rst_overrun", 64'(result_overrun), 64'd0);
      chk("rst_stuck", 64'(stuck), 64'd0);
      resetn = 1'b1;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
         if (result_valid) seen++;
      end
      chk("idle_no_valid", 64'(seen), 64'd0);

      // zero inputs: fixed signature and stuck timing
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         drv(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
         chk("stuck_timing", 64'(stuck), (k >= 10) ? 64'd1 : 64'd0);
         if (k == 5) begin
            chk("zero_valid", 64'(result_valid), 64'd1);
            chk("zero_signature", 64'(result_signature), 64'hC7B0424D);
            chk("zero_toggles", 64'(result_toggles), 64'd0);
         end
      end
      drain();

      // alternating data toggles
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         alt = k[0] ? 16'h0000 : 16'hFFFF;
         drv(1'b1, 1'b0, 16'h1234, alt, 1'b1);
         if (k == 5) chk("alt_first_toggles", 64'(result_toggles), 64'd48);
         if (k == 9) chk("alt_next_toggles", 64'(result_toggles), 64'd64);
      end
      chk("alt_stuck", 64'(stuck), 64'd0);
      drain();

      // backpressure across two window ends
      do_reset();
      drop_mode = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         alt = k[0] ? 16'h0000 : 16'hFFFF;
         drv(1'b1, 1'b0, 16'h1234, alt, 1'b0);
         if (k == 5) begin
            chk("bp_valid", 64'(result_valid), 64'd1);
            chk("bp_overrun_first", 64'(result_overrun), 64'd0);
            chk("bp_sb_depth", 64'(sb.size()), 64'd1);
         end
      end
      chk("bp_held_valid", 64'(result_valid), 64'd1);
      chk("bp_overrun", 64'(result_overrun), 64'd1);
      chk("bp_held_signature", 64'(result_signature), 64'(sb[0].sig));
      chk("bp_held_toggles", 64'(result_toggles), 64'd48);
      drop_mode = 1'b0;
      drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      chk("bp_valid_drop", 64'(result_valid), 64'd0);
      chk("bp_overrun_clear", 64'(result_overrun), 64'd0);
      drain();

      // reset two updates into a window
      do_reset();
      for (int k = 1; k <= 7; k++) drv(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("mid_pre_valid", 64'(result_valid), 64'd1);
      resetn = 1'b0;
      model_reset();
      sb.delete();
      #1;
      chk("mid_async_valid", 64'(result_valid), 64'd0);
      chk("mid_async_signature", 64'(result_signature), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drv(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
         if (k == 4) chk("mid_not_early", 64'(result_valid), 64'd0);
         if (k == 5) begin
            chk("mid_valid", 64'(result_valid), 64'd1);
            chk("mid_signature", 64'(result_signature), 64'hC7B0424D);
         end
      end
      drain();

      // enable pause mid-window
      do_reset();
      drv(1'b1, 1'b0, 16'h0, 16'h0000, 1'b1);
      drv(1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b1);
      repeat (10) drv(1'b0, 1'b1, 16'hA5A5, 16'h5555, 1'b1);
      drv(1'b1, 1'b0, 16'h0, 16'h0000, 1'b1);
      drv(1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b1);
      chk("pause_not_early", 64'(result_valid), 64'd0);
      drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      chk("pause_valid", 64'(result_valid), 64'd1);
      chk("pause_toggles", 64'(result_toggles), 64'd32);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
